// File: rtl/efi_pkg.sv
// efi_pkg: definitions shared by the crank-wheel generator and the engine
// synchronizer.
//   CFG_W         - default width of the tooth-count / teeth-missing words,
//                   tooth index and revolution counter
//   PER_W         - default width of the tooth-period word
//   wheel_state_t - generator state encoding
//   cfg_valid()   - wheel geometry / speed sanity check
package efi_pkg;

  localparam int CFG_W = 16;
  localparam int PER_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wheel_state_t;

  // Arguments are 32 bits wide so callers with narrower or wider words can
  // zero-extend into them. A usable wheel needs at least two positions, at
  // least one real tooth, and a period long enough to hold a high half.
  function automatic logic cfg_valid(input logic [31:0] tooth_cnt,
                                     input logic [31:0] teeth_missing,
                                     input logic [31:0] tooth_period);
    return (tooth_cnt >= 32'd2) &&
           (teeth_missing < tooth_cnt) &&
           (tooth_period >= 32'd2);
  endfunction

endpackage

// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: missing-tooth crank trigger-wheel generator. Produces the
// digital equivalent of a conditioned VR sensor output for self-test and HIL.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   enable         in   run the wheel; low forces idle
//   tooth_cnt      in   tooth positions per revolution, gap included
//   teeth_missing  in   gap positions at the end of the revolution
//   tooth_period   in   clocks per tooth position
//   vr_out         out  tooth waveform, high for the first half of a real tooth
//   sync_pulse     out  one-clock strobe on the first clock of position 0
//   tooth_index    out  current position
//   rev_count      out  completed revolutions since start (wrapping)
//   running        out  high while in RUN
//   config_err     out  sticky invalid-configuration flag
//
// State table
//   state   | meaning
//   ST_IDLE | outputs low, counters cleared, waiting for enable + valid config
//   ST_RUN  | wheel turning: phase/position/revolution counters advancing
module crank_wheel_gen #(
  parameter int CFG_W = efi_pkg::CFG_W,
  parameter int PER_W = efi_pkg::PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CFG_W-1:0] tooth_cnt,
  input  logic [CFG_W-1:0] teeth_missing,
  input  logic [PER_W-1:0] tooth_period,
  output logic             vr_out,
  output logic             sync_pulse,
  output logic [CFG_W-1:0] tooth_index,
  output logic [CFG_W-1:0] rev_count,
  output logic             running,
  output logic             config_err
);

  import efi_pkg::*;

  wheel_state_t     r_state,  w_state_n;
  logic [PER_W-1:0] r_phase,  w_phase_n;
  logic [PER_W-1:0] r_period, w_period_n;
  logic [CFG_W-1:0] r_pos,    w_pos_n;
  logic [CFG_W-1:0] r_cnt,    w_cnt_n;
  logic [CFG_W-1:0] r_miss,   w_miss_n;
  logic [CFG_W-1:0] r_rev,    w_rev_n;
  logic             r_vr,     w_vr_n;
  logic             r_sync,   w_sync_n;
  logic             r_run,    w_run_n;
  logic             r_err,    w_err_n;

  logic             w_cfg_ok;
  logic             w_period_ok;
  logic             w_pos_end;
  logic             w_rev_end;
  logic [CFG_W-1:0] w_pos_inc;
  logic [PER_W-1:0] w_phase_inc;
  logic [CFG_W-1:0] w_real_teeth;

  assign w_cfg_ok     = cfg_valid(32'(tooth_cnt), 32'(teeth_missing),
                                  32'(tooth_period));
  assign w_period_ok  = (tooth_period >= PER_W'(2));
  assign w_pos_end    = (r_phase == r_period - PER_W'(1));
  assign w_rev_end    = (r_pos == r_cnt - CFG_W'(1));
  assign w_pos_inc    = r_pos + CFG_W'(1);
  assign w_phase_inc  = r_phase + PER_W'(1);
  assign w_real_teeth = r_cnt - r_miss;

  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_period_n = r_period;
    w_pos_n    = r_pos;
    w_cnt_n    = r_cnt;
    w_miss_n   = r_miss;
    w_rev_n    = r_rev;
    w_vr_n     = 1'b0;
    w_sync_n   = 1'b0;
    w_run_n    = 1'b0;
    w_err_n    = r_err;

    unique case (r_state)
      ST_IDLE: begin
        w_phase_n = '0;
        w_pos_n   = '0;
        w_rev_n   = '0;
        if (enable) begin
          if (w_cfg_ok) begin
            // Valid config guarantees position 0 is a real tooth and the
            // half-period is at least one clock, so the first sample is high.
            w_state_n  = ST_RUN;
            w_cnt_n    = tooth_cnt;
            w_miss_n   = teeth_missing;
            w_period_n = tooth_period;
            w_vr_n     = 1'b1;
            w_sync_n   = 1'b1;
            w_run_n    = 1'b1;
            w_err_n    = 1'b0;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Enable drop beats everything, including a pending wrap.
          w_state_n = ST_IDLE;
          w_phase_n = '0;
          w_pos_n   = '0;
          w_rev_n   = '0;
        end else if (w_pos_end && w_rev_end) begin
          if (w_cfg_ok) begin
            w_phase_n  = '0;
            w_pos_n    = '0;
            w_cnt_n    = tooth_cnt;
            w_miss_n   = teeth_missing;
            w_period_n = tooth_period;
            w_rev_n    = r_rev + CFG_W'(1);
            w_vr_n     = 1'b1;
            w_sync_n   = 1'b1;
            w_run_n    = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
            w_phase_n = '0;
            w_pos_n   = '0;
            w_rev_n   = '0;
            w_err_n   = 1'b1;
          end
        end else if (w_pos_end) begin
          // Mid-revolution only the period is re-latched. A period too short
          // to form a tooth is flagged and the previous period kept; the
          // revolution boundary check then takes the wheel down.
          w_phase_n = '0;
          w_pos_n   = w_pos_inc;
          if (w_period_ok) begin
            w_period_n = tooth_period;
          end else begin
            w_err_n = 1'b1;
          end
          w_vr_n  = (w_pos_inc < w_real_teeth);
          w_run_n = 1'b1;
        end else begin
          w_phase_n = w_phase_inc;
          w_vr_n    = (r_pos < w_real_teeth) && (w_phase_inc < (r_period >> 1));
          w_run_n   = 1'b1;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_period <= '0;
      r_pos    <= '0;
      r_cnt    <= '0;
      r_miss   <= '0;
      r_rev    <= '0;
      r_vr     <= 1'b0;
      r_sync   <= 1'b0;
      r_run    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_phase  <= w_phase_n;
      r_period <= w_period_n;
      r_pos    <= w_pos_n;
      r_cnt    <= w_cnt_n;
      r_miss   <= w_miss_n;
      r_rev    <= w_rev_n;
      r_vr     <= w_vr_n;
      r_sync   <= w_sync_n;
      r_run    <= w_run_n;
      r_err    <= w_err_n;
    end
  end

  assign vr_out      = r_vr;
  assign sync_pulse  = r_sync;
  assign tooth_index = r_pos;
  assign rev_count   = r_rev;
  assign running     = r_run;
  assign config_err  = r_err;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb_crank_wheel_gen: self-checking bench for crank_wheel_gen.
// A second instance with 8-bit counters exercises the revolution counter wrap.
module tb_crank_wheel_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable;
  logic [15:0] tooth_cnt;
  logic [15:0] teeth_missing;
  logic [31:0] tooth_period;
  logic        vr_out, sync_pulse, running, config_err;
  logic [15:0] tooth_index, rev_count;

  logic        enable2;
  logic [7:0]  tooth_cnt2, teeth_missing2;
  logic [31:0] tooth_period2;
  logic        vr_out2, sync_pulse2, running2, config_err2;
  logic [7:0]  tooth_index2, rev_count2;

  crank_wheel_gen dut (
    .clk(clk), .reset(reset), .enable(enable),
    .tooth_cnt(tooth_cnt), .teeth_missing(teeth_missing),
    .tooth_period(tooth_period),
    .vr_out(vr_out), .sync_pulse(sync_pulse), .tooth_index(tooth_index),
    .rev_count(rev_count), .running(running), .config_err(config_err)
  );

  crank_wheel_gen #(.CFG_W(8), .PER_W(32)) dut8 (
    .clk(clk), .reset(reset), .enable(enable2),
    .tooth_cnt(tooth_cnt2), .teeth_missing(teeth_missing2),
    .tooth_period(tooth_period2),
    .vr_out(vr_out2), .sync_pulse(sync_pulse2), .tooth_index(tooth_index2),
    .rev_count(rev_count2), .running(running2), .config_err(config_err2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cnt;
    int unsigned miss;
    int unsigned per;
    int unsigned ncyc;
    logic [15:0] pat;       // vr_out for the first 16 clocks, MSB first
    int unsigned sync_per;  // clocks between sync pulses
  } vec_t;

  typedef struct {
    logic        vr;
    logic        sync;
    logic [15:0] idx;
    logic [15:0] rev;
  } exp_t;

  vec_t vecs[4];
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    enable = 1'b0;
    tick;
    tick;
    reset  = 1'b0;
  endtask

  task automatic set_cfg(input int unsigned c, input int unsigned m,
                         input int unsigned p);
    tooth_cnt     = 16'(c);
    teeth_missing = 16'(m);
    tooth_period  = p;
  endtask

  initial begin
    vecs[0] = '{cnt: 4, miss: 1, per: 4, ncyc: 48, pat: 16'hCCC0, sync_per: 16};
    vecs[1] = '{cnt: 3, miss: 0, per: 3, ncyc: 27, pat: 16'h9249, sync_per: 9};
    vecs[2] = '{cnt: 5, miss: 2, per: 5, ncyc: 50, pat: 16'hC630, sync_per: 25};
    vecs[3] = '{cnt: 2, miss: 1, per: 2, ncyc: 20, pat: 16'h8888, sync_per: 4};

    reset = 1'b1; enable = 1'b0; set_cfg(4, 1, 4);
    enable2 = 1'b0; tooth_cnt2 = 8'd2; teeth_missing2 = 8'd0; tooth_period2 = 32'd2;
    tick; tick;
    reset = 1'b0;
    tick;
    check("reset vr_out",      32'(vr_out),      32'd0);
    check("reset sync_pulse",  32'(sync_pulse),  32'd0);
    check("reset tooth_index", 32'(tooth_index), 32'd0);
    check("reset rev_count",   32'(rev_count),   32'd0);
    check("reset running",     32'(running),     32'd0);
    check("reset config_err",  32'(config_err),  32'd0);

    // Table-driven constant-speed runs.
    foreach (vecs[v]) begin
      exp_t e;
      do_reset;
      set_cfg(vecs[v].cnt, vecs[v].miss, vecs[v].per);
      enable = 1'b1;
      for (int t = 0; t < int'(vecs[v].ncyc); t++) begin
        int unsigned ut, pos, ph;
        ut  = int'(t);
        pos = (ut / vecs[v].per) % vecs[v].cnt;
        ph  = ut % vecs[v].per;
        if (t < 16) e.vr = vecs[v].pat[15 - t];
        else        e.vr = (pos < vecs[v].cnt - vecs[v].miss) && (ph < vecs[v].per / 2);
        e.sync = ((ut % vecs[v].sync_per) == 0);
        e.idx  = 16'(pos);
        e.rev  = 16'(ut / vecs[v].sync_per);
        sbq.push_back(e);
      end
      for (int t = 0; t < int'(vecs[v].ncyc); t++) begin
        tick;
        e = sbq.pop_front();
        check($sformatf("v%0d t%0d vr_out", v, t),      32'(vr_out),      32'(e.vr));
        check($sformatf("v%0d t%0d sync_pulse", v, t),  32'(sync_pulse),  32'(e.sync));
        check($sformatf("v%0d t%0d tooth_index", v, t), 32'(tooth_index), 32'(e.idx));
        check($sformatf("v%0d t%0d rev_count", v, t),   32'(rev_count),   32'(e.rev));
        check($sformatf("v%0d t%0d running", v, t),     32'(running),     32'd1);
      end
      enable = 1'b0;
      tick;
      check($sformatf("v%0d stop running", v), 32'(running), 32'd0);
      check($sformatf("v%0d stop vr_out", v),  32'(vr_out),  32'd0);
    end

    // Period change mid-revolution; geometry change deferred to position 0.
    do_reset;
    set_cfg(4, 1, 4);
    enable = 1'b1;
    for (int t = 0; t <= 64; t++) begin
      tick;
      if (t == 5) begin
        tooth_period = 32'd8;
        tooth_cnt    = 16'd5;
      end
      case (t)
        8:  begin check("pchg t8 idx", 32'(tooth_index), 32'd2);
                  check("pchg t8 vr",  32'(vr_out),      32'd1); end
        11: check("pchg t11 vr", 32'(vr_out), 32'd1);
        12: begin check("pchg t12 idx", 32'(tooth_index), 32'd2);
                  check("pchg t12 vr",  32'(vr_out),      32'd0); end
        15: check("pchg t15 idx", 32'(tooth_index), 32'd2);
        16: begin check("pchg t16 idx", 32'(tooth_index), 32'd3);
                  check("pchg t16 vr",  32'(vr_out),      32'd0); end
        23: check("pchg t23 sync", 32'(sync_pulse), 32'd0);
        24: begin check("pchg t24 idx",  32'(tooth_index), 32'd0);
                  check("pchg t24 sync", 32'(sync_pulse),  32'd1);
                  check("pchg t24 rev",  32'(rev_count),   32'd1); end
        48: begin check("pchg t48 idx", 32'(tooth_index), 32'd3);
                  check("pchg t48 vr",  32'(vr_out),      32'd1); end
        56: begin check("pchg t56 idx", 32'(tooth_index), 32'd4);
                  check("pchg t56 vr",  32'(vr_out),      32'd0); end
        63: check("pchg t63 sync", 32'(sync_pulse), 32'd0);
        64: begin check("pchg t64 sync", 32'(sync_pulse), 32'd1);
                  check("pchg t64 rev",  32'(rev_count),  32'd2); end
        default: ;
      endcase
    end

    // Invalid config held in IDLE, then recovery clears the flag.
    do_reset;
    set_cfg(4, 4, 4);
    enable = 1'b1;
    tick;
    check("inv running", 32'(running),    32'd0);
    check("inv err",     32'(config_err), 32'd1);
    check("inv vr",      32'(vr_out),     32'd0);
    tick;
    check("inv hold vr",  32'(vr_out),     32'd0);
    check("inv hold err", 32'(config_err), 32'd1);
    teeth_missing = 16'd1;
    tick;
    check("recover running", 32'(running),    32'd1);
    check("recover err",     32'(config_err), 32'd0);
    check("recover sync",    32'(sync_pulse), 32'd1);
    check("recover vr",      32'(vr_out),     32'd1);
    enable = 1'b0;
    teeth_missing = 16'd4;
    tick;
    enable = 1'b1;
    tick;
    check("inv again err", 32'(config_err), 32'd1);
    do_reset;
    check("reset clears err", 32'(config_err), 32'd0);

    // Enable dropped on the wrap clock.
    set_cfg(4, 1, 4);
    enable = 1'b1;
    for (int t = 0; t < 16; t++) tick;
    check("drop pre idx", 32'(tooth_index), 32'd3);
    enable = 1'b0;
    tick;
    check("drop sync",    32'(sync_pulse),  32'd0);
    check("drop running", 32'(running),     32'd0);
    check("drop vr",      32'(vr_out),      32'd0);
    check("drop rev",     32'(rev_count),   32'd0);
    check("drop idx",     32'(tooth_index), 32'd0);

    // Mid-tooth stop: no tooth completion.
    enable = 1'b1;
    tick;
    check("midstop start vr", 32'(vr_out), 32'd1);
    enable = 1'b0;
    tick;
    check("midstop vr",      32'(vr_out),  32'd0);
    check("midstop running", 32'(running), 32'd0);

    // Config made invalid mid-revolution: takes effect at the wrap.
    do_reset;
    set_cfg(4, 1, 4);
    enable = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      tick;
      if (t == 10) teeth_missing = 16'd4;
      if (t == 15) check("invwrap t15 running", 32'(running), 32'd1);
    end
    check("invwrap running", 32'(running),    32'd0);
    check("invwrap err",     32'(config_err), 32'd1);
    check("invwrap sync",    32'(sync_pulse), 32'd0);

    // Reset mid-revolution.
    do_reset;
    set_cfg(4, 1, 4);
    enable = 1'b1;
    for (int t = 0; t < 6; t++) tick;
    reset = 1'b1;
    tick;
    check("midrst running", 32'(running),     32'd0);
    check("midrst idx",     32'(tooth_index), 32'd0);
    check("midrst vr",      32'(vr_out),      32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    tick;

    // Revolution counter wrap on the 8-bit instance: 4 clocks per revolution.
    enable2 = 1'b1;
    for (int t = 0; t <= 1024; t++) begin
      tick;
      if (t == 4)    check("wrap8 t4 rev",    32'(rev_count2), 32'd1);
      if (t == 1020) check("wrap8 t1020 rev", 32'(rev_count2), 32'd255);
    end
    check("wrap8 rev",     32'(rev_count2),   32'd0);
    check("wrap8 sync",    32'(sync_pulse2),  32'd1);
    check("wrap8 idx",     32'(tooth_index2), 32'd0);
    check("wrap8 vr",      32'(vr_out2),      32'd1);
    check("wrap8 running", 32'(running2),     32'd1);
    check("wrap8 err",     32'(config_err2),  32'd0);
    enable2 = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
